// File: rtl/sync_in_multi.sv
// Multi-channel sync-input synchroniser, glitch filter and per-channel edge-pulse generator.
// Optional per-channel watchdog enabled by defining SYNC_TIMEOUT_EN.
module sync_in_multi #(
    parameter int NUM_CH         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     sync_in,
    input  logic [2*NUM_CH-1:0]   edge_mode,
    output logic [NUM_CH-1:0]     sync_level,
    output logic [NUM_CH-1:0]     sync_pulse,
    output logic                  sync_pulse_any,
    output logic [NUM_CH-1:0]     sync_timeout
);

    localparam int CNT_W = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_CYCLES);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    logic [NUM_CH-1:0] pulse_d;
    logic              pulse_any_d;
    logic              pulse_any_q;

    generate
        if (NUM_CH < 1 || SYNC_STAGES < 2 || FILTER_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("sync_in_multi: illegal parameter value");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_d, sync_q;
            logic [CNT_W-1:0]       cnt_d, cnt_q;
            state_t                 state_d, state_q;
            logic                   pulse_q;
            logic                   pulse_nxt;
            logic                   s;
            logic [1:0]             mode;

            assign s    = sync_q[SYNC_STAGES-1];
            assign mode = edge_mode[2*gi+1 -: 2];

            // Filter counts consecutive samples that disagree with the accepted level.
            always_comb begin
                sync_d    = {sync_q[SYNC_STAGES-2:0], sync_in[gi]};
                cnt_d     = '0;
                state_d   = state_q;
                pulse_nxt = 1'b0;
                if (s == (state_q == ST_HIGH)) begin
                    cnt_d = '0;
                end else if (cnt_q != FILT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d   = (state_q == ST_HIGH) ? ST_LOW : ST_HIGH;
                    pulse_nxt = s ? mode[0] : mode[1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_LOW;
                    pulse_q <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    cnt_q   <= cnt_d;
                    state_q <= state_d;
                    pulse_q <= pulse_nxt;
                end
            end

            assign pulse_d[gi]    = pulse_nxt;
            assign sync_level[gi] = (state_q == ST_HIGH);
            assign sync_pulse[gi] = pulse_q;

`ifdef SYNC_TIMEOUT_EN
            localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
            localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

            logic [TO_W-1:0] wd_d, wd_q;
            logic            timeout_d, timeout_q;

            // Saturating watchdog; a disabled channel never times out.
            always_comb begin
                wd_d = wd_q;
                if (pulse_q || mode == 2'b00) begin
                    wd_d = '0;
                end else if (wd_q != TO_MAX) begin
                    wd_d = wd_q + TO_W'(1);
                end
                timeout_d = (wd_d == TO_MAX);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wd_q      <= '0;
                    timeout_q <= 1'b0;
                end else begin
                    wd_q      <= wd_d;
                    timeout_q <= timeout_d;
                end
            end

            assign sync_timeout[gi] = timeout_q;
`else
            assign sync_timeout[gi] = 1'b0;
`endif
        end
    endgenerate

    always_comb begin
        pulse_any_d = |pulse_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_any_q <= 1'b0;
        end else begin
            pulse_any_q <= pulse_any_d;
        end
    end

    assign sync_pulse_any = pulse_any_q;

endmodule

// File: tb/tb_sync_in_multi.sv
// Directed bench for sync_in_multi: default instance plus a FILTER_CYCLES=3 instance.
module tb_sync_in_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_f;
    logic [3:0] in_a, in_f;
    logic [7:0] mode_a, mode_f;
    logic [3:0] lvl_a, pul_a, to_a;
    logic [3:0] lvl_f, pul_f, to_f;
    logic       any_a, any_f;

    int checks   = 0;
    int failures = 0;

    sync_in_multi #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0), .TIMEOUT_CYCLES(50)
    ) dut_a (
        .clk(clk), .rst(rst_a), .sync_in(in_a), .edge_mode(mode_a),
        .sync_level(lvl_a), .sync_pulse(pul_a), .sync_pulse_any(any_a),
        .sync_timeout(to_a)
    );

    sync_in_multi #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .TIMEOUT_CYCLES(50)
    ) dut_f (
        .clk(clk), .rst(rst_f), .sync_in(in_f), .edge_mode(mode_f),
        .sync_level(lvl_f), .sync_pulse(pul_f), .sync_pulse_any(any_f),
        .sync_timeout(to_f)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int first_t;
        int last_t;

        rst_a = 1'b1; rst_f = 1'b1;
        in_a = '0; in_f = '0;
        mode_a = 8'h55; mode_f = 8'h55;
        tick(3);
        check_val("rst_level_a", {28'd0, lvl_a}, 32'd0);
        check_val("rst_pulse_a", {27'd0, any_a, pul_a}, 32'd0);
        check_val("rst_timeout_a", {28'd0, to_a}, 32'd0);
        check_val("rst_all_f", {15'd0, any_f, pul_f, lvl_f, to_f}, 32'd0);
        rst_a = 1'b0; rst_f = 1'b0;
        tick(6);

        // Rising edge on ch0: pulse exactly three edges later
        in_a[0] = 1'b1;
        tick(2);
        check_val("rise_early_pulse", {28'd0, pul_a}, 32'd0);
        tick(1);
        check_val("rise_pulse", {28'd0, pul_a}, 32'h1);
        check_val("rise_level", {28'd0, lvl_a}, 32'h1);
        check_val("rise_any", {31'd0, any_a}, 32'd1);
        tick(1);
        check_val("rise_pulse_one_cycle", {27'd0, any_a, pul_a}, 32'd0);
        check_val("rise_level_hold", {28'd0, lvl_a}, 32'h1);

        in_a[0] = 1'b0;
        cnt = 0;
        for (int t = 1; t <= 6; t++) begin
            tick(1);
            if (pul_a != 4'd0) cnt++;
        end
        check_val("fall_mode01_no_pulse", cnt, 32'd0);
        check_val("fall_level", {28'd0, lvl_a}, 32'd0);

        // Disabled channel still tracks the level
        mode_a[3:2] = 2'b00;
        in_a[1] = 1'b1;
        tick(3);
        check_val("mode00_level", {28'd0, lvl_a}, 32'h2);
        check_val("mode00_no_pulse", {28'd0, pul_a}, 32'd0);
        in_a[1] = 1'b0;
        mode_a[3:2] = 2'b01;
        tick(5);

        // Both-edge mode on ch2: 20-cycle pulse gives two pulses 20 apart
        mode_a[5:4] = 2'b11;
        in_a[2] = 1'b1;
        cnt = 0; first_t = -1; last_t = -1;
        for (int t = 1; t <= 30; t++) begin
            tick(1);
            if (pul_a[2]) begin
                cnt++;
                if (first_t < 0) first_t = t;
                last_t = t;
            end
            if (t == 20) in_a[2] = 1'b0;
        end
        check_val("both_count", cnt, 32'd2);
        check_val("both_first", first_t, 32'd3);
        check_val("both_last", last_t, 32'd23);

        mode_a[5:4] = 2'b10;
        in_a[2] = 1'b1;
        cnt = 0; first_t = -1;
        for (int t = 1; t <= 30; t++) begin
            tick(1);
            if (pul_a[2]) begin
                cnt++;
                if (first_t < 0) first_t = t;
            end
            if (t == 20) in_a[2] = 1'b0;
        end
        check_val("fallonly_count", cnt, 32'd1);
        check_val("fallonly_time", first_t, 32'd23);

        // Simultaneous edges on ch0 and ch3
        mode_a = 8'h55;
        in_a[0] = 1'b1; in_a[3] = 1'b1;
        tick(3);
        check_val("simul_pulse", {28'd0, pul_a}, 32'h9);
        check_val("simul_any", {31'd0, any_a}, 32'd1);
        tick(1);
        check_val("simul_after", {27'd0, any_a, pul_a}, 32'd0);
        in_a[0] = 1'b0; in_a[3] = 1'b0;
        tick(5);
`ifndef SYNC_TIMEOUT_EN
        check_val("no_timeout_a", {28'd0, to_a}, 32'd0);
`endif

        // Filtered instance: 3-cycle glitch rejected
        in_f[1] = 1'b1;
        tick(3);
        in_f[1] = 1'b0;
        cnt = 0;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            if (pul_f != 4'd0 || lvl_f != 4'd0) cnt++;
        end
        check_val("glitch_rejected", cnt, 32'd0);

        // 4-cycle high accepted, pulse six edges after the rise
        in_f[1] = 1'b1;
        cnt = 0; first_t = -1;
        for (int t = 1; t <= 14; t++) begin
            tick(1);
            if (pul_f[1]) begin
                cnt++;
                if (first_t < 0) first_t = t;
            end
            if (t == 4) in_f[1] = 1'b0;
        end
        check_val("filt_count", cnt, 32'd1);
        check_val("filt_time", first_t, 32'd6);
        check_val("filt_level_back", {28'd0, lvl_f}, 32'd0);

        // Reset with filter counter at 2 of 3 and ch1 held high
        in_f[1] = 1'b1;
        tick(4);
        rst_f = 1'b1;
        tick(1);
        check_val("midrst_outputs", {15'd0, any_f, pul_f, lvl_f, to_f}, 32'd0);
        rst_f = 1'b0;
        cnt = 0; first_t = -1;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            if (pul_f[1]) begin
                cnt++;
                if (first_t < 0) first_t = t;
            end
        end
        check_val("midrst_count", cnt, 32'd1);
        check_val("midrst_time", first_t, 32'd6);
        check_val("midrst_any_idle", {31'd0, any_f}, 32'd0);
        in_f[1] = 1'b0;
        tick(8);

`ifdef SYNC_TIMEOUT_EN
        rst_a = 1'b1;
        in_a = '0;
        mode_a = 8'h55;
        tick(1);
        rst_a = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            tick(1);
            if (t == 49) check_val("to_before", {31'd0, to_a[0]}, 32'd0);
            if (t == 50) check_val("to_rise", {31'd0, to_a[0]}, 32'd1);
            if (t == 60) check_val("to_hold", {31'd0, to_a[0]}, 32'd1);
        end
        in_a[0] = 1'b1;
        tick(3);
        check_val("to_pulse", {28'd0, pul_a}, 32'h1);
        check_val("to_still_set", {31'd0, to_a[0]}, 32'd1);
        tick(1);
        check_val("to_cleared", {31'd0, to_a[0]}, 32'd0);
`else
        check_val("no_timeout_f", {28'd0, to_f}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
